// File: rtl/fetch0_pkg.sv
// rtl/fetch0_pkg.sv - shared types and constants for the fetch stage
// Purpose: exception cause encoding, reset PC default, output-queue entry layout.
package fetch0_pkg;

  typedef enum logic [3:0] {
    ECAUSE_NONE = 4'd0,
    IFAULT      = 4'd1,
    ILLEGAL     = 4'd2,
    BREAKPOINT  = 4'd3
  } ecause_t;

  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0;

  // One buffered fetch result heading to decode: PC[31:2], raw word, fault flag.
  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] insn;
    logic        fault;
  } oq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with clear and async reset
// Ports: clk/rst (async active-high), clear (sync flush), push/wdata,
//        pop, rdata (head, combinational), full, empty, count (occupancy).
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch0.sv
// rtl/fetch0.sv - instruction-fetch front stage (PC, icache requests, decode buffer)
// Ports: clk_core/reset (async active-high); csr_kill, csr_fe_inhibit,
//        csr_setpc/csr_newpc and ex_br_taken/ex_br_target redirect controls;
//        ic_req_* request channel, ic_resp_* in-order response channel;
//        fe_* instruction channel toward decode.
module fetch0
  import fetch0_pkg::*;
#(
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        csr_kill,
  input  logic        csr_fe_inhibit,
  input  logic        csr_setpc,
  input  logic [29:0] csr_newpc,
  input  logic        ex_br_taken,
  input  logic [29:0] ex_br_target,
  output logic        ic_req_valid,
  input  logic        ic_req_ready,
  output logic [29:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_data,
  input  logic        ic_resp_fault,
  output logic        fe_valid,
  input  logic        fe_ready,
  output logic [29:0] fe_pc,
  output logic [31:0] fe_insn,
  output logic        fe_exc,
  output ecause_t     fe_exc_cause
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [29:0]   pc_q, pc_d;
  logic [CW-1:0] live_q, live_d, drop_q, drop_d;

  logic          redir, flush, hs;
  logic [29:0]   target;
  logic [CW+1:0] credit_used;
  logic [CW-1:0] drop_base;
  logic          resp_drop, resp_keep;

  logic [29:0]   tag_head;
  logic          tag_full, tag_empty;
  logic [CW-1:0] tag_count;

  oq_entry_t     oq_wdata, oq_head;
  logic          oq_full, oq_empty, oq_pop;
  logic [CW-1:0] oq_count;

  always_comb begin
    redir  = csr_setpc | ex_br_taken;
    target = csr_setpc ? csr_newpc : ex_br_target;
    flush  = csr_kill | ex_br_taken;

    // Every slot is counted from issue until decode takes it, including
    // responses that will be thrown away, so the output queue cannot overflow.
    credit_used  = (CW+2)'(live_q) + (CW+2)'(drop_q) + (CW+2)'(oq_count);
    ic_req_valid = ~reset & ~csr_fe_inhibit & ~redir & ~flush &
                   (credit_used < (CW+2)'(QDEPTH));
    ic_req_addr  = pc_q;
    hs           = ic_req_valid & ic_req_ready;

    // On flush all live fetches become drops first; a response landing in the
    // same cycle then consumes one of those drops.
    drop_base = flush ? (drop_q + live_q) : drop_q;
    resp_drop = ic_resp_valid & (drop_base != '0);
    resp_keep = ic_resp_valid & ~resp_drop & ~flush;
    drop_d    = drop_base - CW'(resp_drop);
    live_d    = flush ? '0 : (live_q + CW'(hs) - CW'(resp_keep));

    pc_d = pc_q;
    if (redir)   pc_d = target;
    else if (hs) pc_d = pc_q + 30'd1;
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      live_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      live_q <= live_d;
      drop_q <= drop_d;
    end
  end

  // Tags are popped by every response, kept or dropped, to stay aligned
  // with the in-order cache.
  fetch_fifo #(.WIDTH(30), .DEPTH(QDEPTH)) u_tagq (
    .clk   (clk_core),
    .rst   (reset),
    .clear (1'b0),
    .push  (hs),
    .wdata (pc_q),
    .pop   (ic_resp_valid),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign oq_wdata = '{pc: tag_head, insn: ic_resp_data, fault: ic_resp_fault};
  assign oq_pop   = fe_valid & fe_ready;

  fetch_fifo #(.WIDTH($bits(oq_entry_t)), .DEPTH(QDEPTH)) u_outq (
    .clk   (clk_core),
    .rst   (reset),
    .clear (flush),
    .push  (resp_keep),
    .wdata (oq_wdata),
    .pop   (oq_pop),
    .rdata (oq_head),
    .full  (oq_full),
    .empty (oq_empty),
    .count (oq_count)
  );

  always_comb begin
    fe_valid     = ~oq_empty & ~flush;
    fe_pc        = oq_empty ? RESET_PC : oq_head.pc;
    fe_exc       = ~oq_empty & oq_head.fault;
    fe_insn      = (~oq_empty & ~oq_head.fault) ? oq_head.insn : 32'h0;
    fe_exc_cause = fe_exc ? IFAULT : ECAUSE_NONE;
  end

  logic unused_status;
  assign unused_status = &{1'b0, tag_full, tag_empty, tag_count, oq_full};

endmodule

// File: tb/tb_fetch0.sv
// tb/tb_fetch0.sv - scoreboard bench for fetch0
module tb_fetch0;
  import fetch0_pkg::*;

  localparam int QDEPTH = 2;

  logic        clk_core = 1'b0;
  logic        reset;
  logic        csr_kill, csr_fe_inhibit, csr_setpc, ex_br_taken;
  logic [29:0] csr_newpc, ex_br_target;
  logic        ic_req_valid, ic_req_ready;
  logic [29:0] ic_req_addr;
  logic        ic_resp_valid, ic_resp_fault;
  logic [31:0] ic_resp_data;
  logic        fe_valid, fe_ready, fe_exc;
  logic [29:0] fe_pc;
  logic [31:0] fe_insn;
  ecause_t     fe_exc_cause;

  always #5 clk_core = ~clk_core;

  fetch0 #(.RESET_PC(30'h0), .QDEPTH(QDEPTH)) dut (
    .clk_core(clk_core), .reset(reset),
    .csr_kill(csr_kill), .csr_fe_inhibit(csr_fe_inhibit),
    .csr_setpc(csr_setpc), .csr_newpc(csr_newpc),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_fault(ic_resp_fault),
    .fe_valid(fe_valid), .fe_ready(fe_ready), .fe_pc(fe_pc), .fe_insn(fe_insn),
    .fe_exc(fe_exc), .fe_exc_cause(fe_exc_cause)
  );

  typedef struct { logic [29:0] pc; logic [31:0] insn; logic exc; } fe_exp_t;
  typedef struct { logic [29:0] addr; int due; } pend_t;

  fe_exp_t     exp_fe[$];
  logic [29:0] exp_req[$];
  pend_t       pending[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int lat      = 1;
  logic        fault_en   = 1'b0;
  logic [29:0] fault_addr = 30'h0;

  always @(posedge clk_core) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic ok, input logic [63:0] info);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: value %0h", name, info);
    end
  endtask

  task automatic exp_f(input logic [29:0] pc, input logic [31:0] insn, input logic exc);
    fe_exp_t e;
    e.pc = pc; e.insn = insn; e.exc = exc;
    exp_fe.push_back(e);
  endtask

  // In-order icache model: response `lat` cycles after acceptance.
  initial begin
    pend_t p;
    ic_resp_valid = 1'b0; ic_resp_data = 32'h0; ic_resp_fault = 1'b0;
    forever begin
      @(negedge clk_core);
      ic_resp_valid = 1'b0; ic_resp_data = 32'h0; ic_resp_fault = 1'b0;
      if (reset) pending.delete();
      else if (pending.size() > 0 && pending[0].due <= cyc) begin
        p = pending.pop_front();
        ic_resp_valid = 1'b1;
        ic_resp_fault = fault_en && (p.addr == fault_addr);
        ic_resp_data  = ic_resp_fault ? 32'hDEADBEEF : {p.addr[19:0], 12'h013};
      end
      #1;
      if (!reset && ic_req_valid && ic_req_ready) begin
        hs_cnt++;
        if (exp_req.size() == 0) flag("req_unexpected", 1'b0, 64'(ic_req_addr));
        else check("req_addr", 64'(ic_req_addr), 64'(exp_req.pop_front()));
        p.addr = ic_req_addr; p.due = cyc + lat;
        pending.push_back(p);
      end
      if (!reset) flag("inflight_limit", pending.size() <= QDEPTH, 64'(pending.size()));
    end
  end

  // Decode-side monitor and structural assertions.
  initial begin
    fe_exp_t e;
    forever begin
      @(negedge clk_core);
      #2;
      if (!reset) begin
        if (fe_valid && fe_ready) begin
          if (exp_fe.size() == 0) flag("fe_unexpected", 1'b0, 64'(fe_pc));
          else begin
            e = exp_fe.pop_front();
            check("fe_pc", 64'(fe_pc), 64'(e.pc));
            check("fe_insn", 64'(fe_insn), 64'(e.insn));
            check("fe_exc", 64'(fe_exc), 64'(e.exc));
            check("fe_cause", 64'(fe_exc_cause), 64'(e.exc ? IFAULT : ECAUSE_NONE));
          end
        end
        flag("oq_overflow", !(dut.resp_keep && dut.oq_full && !dut.oq_pop), 64'(dut.oq_count));
        flag("counter_range", (dut.live_q <= QDEPTH) && (dut.drop_q <= QDEPTH),
             {32'(dut.live_q), 32'(dut.drop_q)});
      end
    end
  end

  task automatic wait_hs_rel(input int n);
    int target = hs_cnt + n;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_core);
      if (hs_cnt >= target) return;
    end
    flag("hs_timeout", 1'b0, 64'(hs_cnt));
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_core);
      if (exp_fe.size() == 0 && exp_req.size() == 0 && pending.size() == 0) break;
    end
    flag("drain_done", exp_fe.size() == 0 && exp_req.size() == 0 && pending.size() == 0,
         64'(exp_fe.size() + exp_req.size()));
    exp_fe.delete();
    exp_req.delete();
    repeat (2) @(negedge clk_core);
  endtask

  task automatic run_seq(input int n);
    csr_fe_inhibit = 1'b0;
    wait_hs_rel(n);
    csr_fe_inhibit = 1'b1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; csr_kill = 1'b0; csr_fe_inhibit = 1'b0; csr_setpc = 1'b0;
    csr_newpc = 30'h0; ex_br_taken = 1'b0; ex_br_target = 30'h0;
    ic_req_ready = 1'b1; fe_ready = 1'b1;
    repeat (3) @(negedge clk_core);
    #1;
    check("rst_req_valid", 64'(ic_req_valid), 64'd0);
    check("rst_req_addr", 64'(ic_req_addr), 64'd0);
    check("rst_fe_valid", 64'(fe_valid), 64'd0);
    check("rst_fe_pc", 64'(fe_pc), 64'd0);
    check("rst_fe_insn", 64'(fe_insn), 64'd0);
    check("rst_fe_exc", 64'(fe_exc), 64'd0);

    // Sequential stream 0..5.
    @(negedge clk_core);
    for (int i = 0; i < 6; i++) exp_req.push_back(30'(i));
    exp_f(30'h0, 32'h00000013, 1'b0); exp_f(30'h1, 32'h00001013, 1'b0);
    exp_f(30'h2, 32'h00002013, 1'b0); exp_f(30'h3, 32'h00003013, 1'b0);
    exp_f(30'h4, 32'h00004013, 1'b0); exp_f(30'h5, 32'h00005013, 1'b0);
    reset = 1'b0;
    run_seq(6);

    // Decode stalled for 10 cycles: only the credit limit gets issued.
    begin
      int base;
      exp_req.push_back(30'h6); exp_req.push_back(30'h7);
      exp_f(30'h6, 32'h00006013, 1'b0); exp_f(30'h7, 32'h00007013, 1'b0);
      base = hs_cnt;
      fe_ready = 1'b0; csr_fe_inhibit = 1'b0;
      repeat (10) @(negedge clk_core);
      #1;
      check("bp_req_valid", 64'(ic_req_valid), 64'd0);
      check("bp_issued", 64'(hs_cnt - base), 64'd2);
      @(negedge clk_core);
      csr_fe_inhibit = 1'b1; fe_ready = 1'b1;
      drain();
    end

    // Access fault at pc 8; pc 9 still fetched.
    fault_en = 1'b1; fault_addr = 30'h8;
    exp_req.push_back(30'h8); exp_req.push_back(30'h9);
    exp_f(30'h8, 32'h0, 1'b1); exp_f(30'h9, 32'h00009013, 1'b0);
    run_seq(2);
    fault_en = 1'b0;

    // Branch with two fetches in flight.
    lat = 4;
    exp_req.push_back(30'hA); exp_req.push_back(30'hB);
    exp_req.push_back(30'h100); exp_req.push_back(30'h101);
    exp_f(30'h100, 32'h00100013, 1'b0); exp_f(30'h101, 32'h00101013, 1'b0);
    csr_fe_inhibit = 1'b0;
    wait_hs_rel(2);
    flag("br_two_inflight", pending.size() == 2, 64'(pending.size()));
    ex_br_taken = 1'b1; ex_br_target = 30'h100;
    #1;
    check("br_req_valid", 64'(ic_req_valid), 64'd0);
    @(negedge clk_core);
    ex_br_taken = 1'b0;
    #1;
    check("br_next_addr", 64'(ic_req_addr), 64'h100);
    wait_hs_rel(2);
    csr_fe_inhibit = 1'b1;
    drain();
    lat = 1;

    // Kill + setpc coinciding with a response while the queue holds an entry.
    exp_req.push_back(30'h102); exp_req.push_back(30'h103);
    exp_req.push_back(30'h40); exp_req.push_back(30'h41);
    exp_f(30'h40, 32'h00040013, 1'b0); exp_f(30'h41, 32'h00041013, 1'b0);
    fe_ready = 1'b0; csr_fe_inhibit = 1'b0;
    wait_hs_rel(2);
    csr_fe_inhibit = 1'b1; csr_kill = 1'b1; csr_setpc = 1'b1; csr_newpc = 30'h40;
    #1;
    check("kill_resp_present", 64'(ic_resp_valid), 64'd1);
    check("kill_fe_valid", 64'(fe_valid), 64'd0);
    @(negedge clk_core);
    csr_kill = 1'b0; csr_setpc = 1'b0; csr_fe_inhibit = 1'b0; fe_ready = 1'b1;
    #1;
    check("kill_next_valid", 64'(ic_req_valid), 64'd1);
    check("kill_next_addr", 64'(ic_req_addr), 64'h40);
    wait_hs_rel(2);
    csr_fe_inhibit = 1'b1;
    drain();

    // Inhibit with setpc held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_core);
      csr_setpc = 1'b1; csr_newpc = 30'h20;
      #1;
      check("inh_req_valid", 64'(ic_req_valid), 64'd0);
    end
    @(negedge clk_core);
    csr_setpc = 1'b0;
    exp_req.push_back(30'h20); exp_req.push_back(30'h21);
    exp_f(30'h20, 32'h00020013, 1'b0); exp_f(30'h21, 32'h00021013, 1'b0);
    run_seq(2);

    // PC wrap.
    @(negedge clk_core);
    csr_setpc = 1'b1; csr_newpc = 30'h3FFFFFFF;
    @(negedge clk_core);
    csr_setpc = 1'b0;
    exp_req.push_back(30'h3FFFFFFF); exp_req.push_back(30'h0);
    exp_f(30'h3FFFFFFF, 32'hFFFFF013, 1'b0); exp_f(30'h0, 32'h00000013, 1'b0);
    run_seq(2);

    // Reset mid-operation with a fetch outstanding.
    lat = 3;
    exp_req.push_back(30'h1);
    csr_fe_inhibit = 1'b0;
    wait_hs_rel(1);
    csr_fe_inhibit = 1'b1; reset = 1'b1;
    #1;
    check("mrst_req_valid", 64'(ic_req_valid), 64'd0);
    check("mrst_req_addr", 64'(ic_req_addr), 64'd0);
    check("mrst_fe_valid", 64'(fe_valid), 64'd0);
    @(negedge clk_core);
    @(negedge clk_core);
    reset = 1'b0; lat = 1;
    exp_req.push_back(30'h0);
    exp_f(30'h0, 32'h00000013, 1'b0);
    run_seq(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
